sr_pulse_sequencer: RTL and testbench

//   Upstream command stage for the SR flip-flop (ports S, R, CLK, Q, Q_bar).

---
 rtl/sr_pulse_sequencer_if.sv | 25 ++
 rtl/sr_pulse_sequencer.sv | 130 +++++++++++++
 tb/tb_sr_pulse_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pulse_sequencer_if.sv
// Command/handshake and flip-flop drive bundle for sr_pulse_sequencer.
// master: command source and flip-flop side (supplies Q_FB).
// slave:  the sequencer.
interface sr_pulse_sequencer_if;
  logic REQ_VALID;
  logic SET_REQ;
  logic CLR_REQ;
  logic REQ_READY;
  logic Q_FB;
  logic S;
  logic R;
  logic BUSY;
  logic DONE;
  logic ERR;

  modport master (
    output REQ_VALID, SET_REQ, CLR_REQ, Q_FB,
    input  REQ_READY, S, R, BUSY, DONE, ERR
  );

  modport slave (
    input  REQ_VALID, SET_REQ, CLR_REQ, Q_FB,
    output REQ_READY, S, R, BUSY, DONE, ERR
  );
endinterface

// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer: turns set/clear commands into timed, mutually exclusive
// S/R pulses for an SR flip-flop, then checks Q feedback and reports DONE/ERR.
// Optional feature macro: SR_SEQ_CONFLICT_TOGGLE_EN
//   defined   -> {SET,CLR}={1,1} toggles (target = ~Q_FB at the accepting edge)
//   undefined -> {SET,CLR}={1,1} behaves as clear (reset wins)
module sr_pulse_sequencer #(
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1,
  parameter int unsigned CNT_W     = 4
) (
  input logic                 CLK,
  input logic                 RST,
  sr_pulse_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             target_c;

  // Target Q value for the command currently on the bus.
`ifdef SR_SEQ_CONFLICT_TOGGLE_EN
  assign target_c = (bus.SET_REQ && bus.CLR_REQ) ? ~bus.Q_FB : bus.SET_REQ;
`else
  assign target_c = bus.SET_REQ && !bus.CLR_REQ;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    exp_d   = exp_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ready_q && bus.REQ_VALID && (bus.SET_REQ || bus.CLR_REQ)) begin
          state_d = ST_PULSE;
          exp_d   = target_c;
          s_d     = target_c;
          r_d     = !target_c;
        end
      end
      ST_PULSE: begin
        s_d = s_q;
        r_d = r_q;
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          s_d     = 1'b0;
          r_d     = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_CHECK;
          done_d  = 1'b1;
          err_d   = (bus.Q_FB != exp_q);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Registered datapath and outputs; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.REQ_READY = ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Bench for sr_pulse_sequencer: directed commands, a scoreboard of expected
// pulse lengths / ERR per command, and a monitor that checks each DONE.
module tb_sr_pulse_sequencer;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  sr_pulse_sequencer_if bus ();

  sr_pulse_sequencer #(.PULSE_CYC(2), .GAP_CYC(1), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Behavioural SR flip-flop plus a force override for Q_FB.
  logic q_ff      = 1'b0;
  logic force_en  = 1'b0;
  logic force_val = 1'b0;
  always @(posedge CLK) begin
    if (bus.S) q_ff <= 1'b1;
    else if (bus.R) q_ff <= 1'b0;
  end
  assign bus.Q_FB = force_en ? force_val : q_ff;

  typedef struct {
    int   s_len;
    int   r_len;
    logic err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: invariant every cycle, and per-DONE comparison against the scoreboard.
  int s_run = 0;
  int r_run = 0;
  always @(negedge CLK) begin
    if (RST) begin
      s_run = 0;
      r_run = 0;
    end else begin
      chk("s_and_r_exclusive", 32'(bus.S & bus.R), 32'd0);
      if (bus.S) s_run++;
      if (bus.R) r_run++;
      if (bus.DONE) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("s_pulse_len", 32'(s_run), 32'(e.s_len));
          chk("r_pulse_len", 32'(r_run), 32'(e.r_len));
          chk("err_flag", 32'(bus.ERR), 32'(e.err));
        end
        s_run = 0;
        r_run = 0;
      end
    end
  end

  // Present a command at a negedge once ready; returns #1 after the accepting edge.
  task automatic issue(input logic s, input logic c, input int slen, input int rlen,
                       input logic err, input bit push);
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.REQ_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.REQ_READY) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (push) begin
      exp_t e;
      e.s_len = slen;
      e.r_len = rlen;
      e.err   = err;
      sb_q.push_back(e);
    end
    bus.REQ_VALID = 1'b1;
    bus.SET_REQ   = s;
    bus.CLR_REQ   = c;
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.SET_REQ   = 1'b0;
    bus.CLR_REQ   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.REQ_READY && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!bus.REQ_READY) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.REQ_VALID = 1'b0;
    bus.SET_REQ   = 1'b0;
    bus.CLR_REQ   = 1'b0;

    // Reset behaviour.
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      chk("rst_s",     32'(bus.S),         32'd0);
      chk("rst_r",     32'(bus.R),         32'd0);
      chk("rst_ready", 32'(bus.REQ_READY), 32'd0);
      chk("rst_busy",  32'(bus.BUSY),      32'd0);
      chk("rst_done",  32'(bus.DONE),      32'd0);
      chk("rst_err",   32'(bus.ERR),       32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_before_first_edge", 32'(bus.REQ_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("ready_after_first_edge", 32'(bus.REQ_READY), 32'd1);

    // Set command with the flip-flop attached: exact cycle timing.
    issue(1'b1, 1'b0, 2, 0, 1'b0, 1'b1);
    chk("set_s_cycle_k",   32'(bus.S), 32'd1);
    chk("set_r_cycle_k",   32'(bus.R), 32'd0);
    chk("set_ready_busy",  32'(bus.REQ_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("set_s_cycle_k1",  32'(bus.S), 32'd1);
    @(posedge CLK);
    #1;
    chk("set_s_gap",       32'(bus.S), 32'd0);
    chk("set_busy_gap",    32'(bus.BUSY), 32'd1);
    chk("set_done_gap",    32'(bus.DONE), 32'd0);
    @(posedge CLK);
    #1;
    chk("set_done_k3",     32'(bus.DONE), 32'd1);
    chk("set_err_k3",      32'(bus.ERR), 32'd0);
    chk("set_ready_k3",    32'(bus.REQ_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("set_ready_k4",    32'(bus.REQ_READY), 32'd1);
    chk("set_busy_k4",     32'(bus.BUSY), 32'd0);
    chk("set_done_k4",     32'(bus.DONE), 32'd0);
    chk("q_after_set",     32'(q_ff), 32'd1);

    // NOP command: accepted, no activity.
    issue(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("nop_busy",  32'(bus.BUSY), 32'd0);
    chk("nop_ready", 32'(bus.REQ_READY), 32'd1);

    // Clear command with Q_FB forced high: mismatch reported.
    force_en  = 1'b1;
    force_val = 1'b1;
    issue(1'b0, 1'b1, 0, 2, 1'b1, 1'b1);
    chk("clr_r_cycle_k", 32'(bus.R), 32'd1);
    wait_idle();
    force_en = 1'b0;
    chk("q_after_clr", 32'(q_ff), 32'd0);

    // Conflict command with Q_FB = 0.
`ifdef SR_SEQ_CONFLICT_TOGGLE_EN
    issue(1'b1, 1'b1, 2, 0, 1'b0, 1'b1);
    wait_idle();
    chk("q_after_toggle", 32'(q_ff), 32'd1);
`else
    issue(1'b1, 1'b1, 0, 2, 1'b0, 1'b1);
    wait_idle();
    chk("q_after_conflict", 32'(q_ff), 32'd0);
`endif

    // VALID held with alternating commands while busy: nothing accepted.
    issue(1'b1, 1'b0, 2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.REQ_VALID = 1'b1;
      bus.SET_REQ   = (i % 2) == 0;
      bus.CLR_REQ   = (i % 2) != 0;
      chk("hold_ready_low", 32'(bus.REQ_READY), 32'd0);
      chk("hold_busy",      32'(bus.BUSY), 32'd1);
      @(posedge CLK);
      #1;
    end
    bus.REQ_VALID = 1'b0;
    bus.SET_REQ   = 1'b0;
    bus.CLR_REQ   = 1'b0;
    chk("hold_done", 32'(bus.DONE), 32'd1);
    @(posedge CLK);
    #1;
    chk("hold_ready_after", 32'(bus.REQ_READY), 32'd1);
    chk("hold_busy_after",  32'(bus.BUSY), 32'd0);

    // Reset during the second PULSE cycle: S clears immediately, no DONE.
    issue(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge CLK);
    #2;
    chk("midrst_s_before", 32'(bus.S), 32'd1);
    RST = 1'b1;
    #1;
    chk("midrst_s_after",  32'(bus.S), 32'd0);
    chk("midrst_busy",     32'(bus.BUSY), 32'd0);
    chk("midrst_ready",    32'(bus.REQ_READY), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_ready_rel", 32'(bus.REQ_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("midrst_ready_edge", 32'(bus.REQ_READY), 32'd1);

    // Recovery: a normal set after reset.
    issue(1'b1, 1'b0, 2, 0, 1'b0, 1'b1);
    wait_idle();

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
